// File: rtl/fp32_stream_accumulator_pkg.sv
// Shared definitions for the fp32 stream accumulator: FSM state encoding and fp32 constants.
// The testbench imports this package as well.
package fp32_stream_accumulator_pkg;

    localparam int          FP32_WIDTH = 32;
    localparam logic [31:0] FP32_ZERO  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ieee754_float_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even, with subnormal support.
// The overflow output flags finite operands whose rounded sum exceeds the largest finite value.
module ieee754_float_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        overflow
);

    logic        swap;
    logic [31:0] x;
    logic [31:0] y;
    logic [7:0]  ex;
    logic [7:0]  ey;
    logic [23:0] mx;
    logic [23:0] my;
    logic [7:0]  d;
    logic [4:0]  sh;
    logic [55:0] y_wide;
    logic [26:0] y_al;
    logic [26:0] x_al;
    logic        eff_sub;
    logic [27:0] s_raw;
    logic        any_nan;
    logic        x_inf;
    logic        y_inf;

    // x always holds the operand of larger magnitude, so the subtraction never goes negative.
    assign swap    = b[30:0] > a[30:0];
    assign x       = swap ? b : a;
    assign y       = swap ? a : b;
    assign ex      = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
    assign ey      = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
    assign mx      = {|x[30:23], x[22:0]};
    assign my      = {|y[30:23], y[22:0]};
    assign d       = ex - ey;
    assign sh      = (d > 8'd31) ? 5'd31 : d[4:0];
    assign y_wide  = {my, 32'd0} >> sh;
    assign y_al    = {y_wide[55:30], |y_wide[29:0]};
    assign x_al    = {mx, 3'b000};
    assign eff_sub = x[31] ^ y[31];
    assign s_raw   = eff_sub ? ({1'b0, x_al} - {1'b0, y_al}) : ({1'b0, x_al} + {1'b0, y_al});

    assign any_nan = (&a[30:23] && |a[22:0]) || (&b[30:23] && |b[22:0]);
    assign x_inf   = &x[30:23] && ~|x[22:0];
    assign y_inf   = &y[30:23] && ~|y[22:0];

    logic [9:0]  e;
    logic [26:0] s;
    logic [4:0]  lz;
    logic        found;
    logic [9:0]  shift;
    logic        round_up;
    logic [24:0] m25;
    logic [7:0]  exp_out;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        e        = {2'b00, ex};
        lz       = 5'd27;
        found    = 1'b0;
        shift    = 10'd0;
        result   = 32'd0;
        overflow = 1'b0;

        for (int i = 26; i >= 0; i--) begin
            if (s_raw[i] && !found) begin
                found = 1'b1;
                lz    = 5'(26 - i);
            end
        end

        if (s_raw[27]) begin
            s = {s_raw[27:2], s_raw[1] | s_raw[0]};
            e = e + 10'd1;
        end else begin
            // Left normalisation stops at the minimum exponent, leaving a subnormal.
            shift = ({5'd0, lz} > (e - 10'd1)) ? (e - 10'd1) : {5'd0, lz};
            s     = s_raw[26:0] << shift;
            e     = e - shift;
        end

        round_up = s[2] & (s[1] | s[0] | s[3]);
        m25      = {1'b0, s[26:3]} + 25'(round_up);
        if (m25[24]) begin
            m25 = {1'b0, m25[24:1]};
            e   = e + 10'd1;
        end
        exp_out = m25[23] ? e[7:0] : 8'd0;

        if (any_nan || (x_inf && y_inf && eff_sub)) begin
            result = 32'h7FC0_0000;
        end else if (x_inf) begin
            result = x;
        end else if (s_raw == 28'd0) begin
            result = {x[31] & y[31], 31'd0};
        end else if (e >= 10'd255) begin
            result   = {x[31], 8'hFF, 23'd0};
            overflow = 1'b1;
        end else begin
            result = {x[31], exp_out, m25[22:0]};
        end
    end

endmodule

// File: rtl/fp32_stream_accumulator.sv
// Sums a length-prefixed stream of fp32 words through one combinational adder,
// one element per cycle, and returns the sum with a sticky overflow flag.
module fp32_stream_accumulator
    import fp32_stream_accumulator_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_overflow,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    state_t                state;
    state_t                state_next;
    logic [FP32_WIDTH-1:0] acc;
    logic [CNT_W-1:0]      remaining;
    logic                  sticky;
    logic [FP32_WIDTH-1:0] sum;
    logic                  sum_ovf;
    logic                  accept;

    ieee754_float_adder u_adder (
        .a        (acc),
        .b        (in_data),
        .result   (sum),
        .overflow (sum_ovf)
    );

    assign accept = in_valid && in_ready;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : LOAD;
                end
            end
            LOAD, ACCUM: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_next = (remaining == CNT_W'(1)) ? DONE : ACCUM;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= FP32_ZERO;
            remaining <= '0;
            count     <= '0;
            sticky    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count  <= '0;
                        sticky <= 1'b0;
                        if (len != '0) begin
                            remaining <= len;
                        end else begin
                            acc <= FP32_ZERO;
                        end
                    end
                end
                LOAD: begin
                    // The first element is loaded directly; the adder output is not used.
                    if (accept) begin
                        acc       <= in_data;
                        count     <= count + CNT_W'(1);
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc       <= sum;
                        sticky    <= sticky | sum_ovf;
                        count     <= count + CNT_W'(1);
                        remaining <= remaining - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data     = (state == DONE) ? acc : FP32_ZERO;
    assign out_overflow = (state == DONE) && sticky;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_fp32_stream_accumulator.sv
// Self-checking bench: directed corner cases plus random integer-valued streams,
// whose exact sums are computed with plain integer arithmetic and converted to fp32.
module tb_fp32_stream_accumulator;
    import fp32_stream_accumulator_pkg::*;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_overflow;
    logic             busy;
    logic [CNT_W-1:0] count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] stim_q[$];

    fp32_stream_accumulator #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .len          (len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow),
        .busy         (busy),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact conversion of an integer with magnitude below 2^24 to fp32 bits.
    function automatic logic [31:0] int_to_fp32(input longint v);
        logic [63:0] mag;
        int          p;
        if (v == 0) return FP32_ZERO;
        mag = (v < 0) ? 64'(-v) : 64'(v);
        p = 0;
        for (int i = 0; i < 24; i++) if (mag[i]) p = i;
        return {v < 0, 8'(127 + p), 23'(mag << (23 - p))};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one full command: start, stream stim_q (with random gaps), hold out_ready low
    // for 'stall' cycles, then take the result and confirm the return to idle.
    task automatic run_stream(input string name, input int n, input logic [31:0] exp_data,
                              input logic exp_ovf, input int gap_pct, input int stall);
        int   idx;
        int   cyc;
        logic hs;
        start = 1'b1;
        len   = CNT_W'(n);
        tick();
        start = 1'b0;
        len   = CNT_W'($urandom);
        check({name, "_busy"}, 32'(busy), 32'd1);
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < n * 20 + 50) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? stim_q[idx] : $urandom;
            @(negedge clk);
            hs = in_valid && in_ready;
            tick();
            cyc++;
            if (hs) begin
                idx++;
                check({name, "_count"}, 32'(count), 32'(idx));
            end
        end
        in_valid = 1'b0;
        if (idx < n) check({name, "_timeout"}, 32'(idx), 32'(n));
        check({name, "_out_valid"}, 32'(out_valid), 32'd1);
        check({name, "_in_ready_done"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            check({name, "_hold_data"}, out_data, exp_data);
            check({name, "_hold_ovf"}, 32'(out_overflow), 32'(exp_ovf));
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        check({name, "_data"}, out_data, exp_data);
        check({name, "_ovf"}, 32'(out_overflow), 32'(exp_ovf));
        tick();
        out_ready = 1'b0;
        check({name, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
        if (n != 0) check({name, "_count_held"}, 32'(count), 32'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint sum;
        int     n;
        int     v;

        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_ovf", 32'(out_overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", out_data, FP32_ZERO);
        check("rst_count", 32'(count), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        stim_q = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
        run_stream("basic", 3, 32'h40C0_0000, 1'b0, 0, 0);
        stim_q = '{32'h40A0_0000, 32'hC000_0000};
        run_stream("mixed", 2, 32'h4040_0000, 1'b0, 0, 1);
        stim_q = '{32'h4049_0FDB};
        run_stream("single", 1, 32'h4049_0FDB, 1'b0, 0, 0);
        stim_q = {};
        run_stream("zero_len", 0, FP32_ZERO, 1'b0, 0, 0);
        stim_q = '{32'h7F00_0000, 32'h7F00_0000};
        run_stream("overflow", 2, 32'h7F80_0000, 1'b1, 0, 5);

        // A start pulse mid-stream must neither restart nor re-length the stream.
        start = 1'b1; len = CNT_W'(3); tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'h3F80_0000; tick();
        check("ign_count1", 32'(count), 32'd1);
        in_valid = 1'b0; start = 1'b1; len = CNT_W'(9); tick(); start = 1'b0;
        check("ign_gap_count", 32'(count), 32'd1);
        check("ign_gap_busy", 32'(busy), 32'd1);
        in_valid = 1'b1; in_data = 32'h4000_0000; tick();
        in_data = 32'h4040_0000; tick();
        in_valid = 1'b0;
        check("ign_done_valid", 32'(out_valid), 32'd1);
        check("ign_done_data", out_data, 32'h40C0_0000);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Reset mid-stream after two elements of a four-element stream.
        start = 1'b1; len = CNT_W'(4); tick(); start = 1'b0;
        in_valid = 1'b1; in_data = 32'h4120_0000; tick();
        in_valid = 1'b0; tick();
        check("rs_gap_count", 32'(count), 32'd1);
        in_valid = 1'b1; in_data = 32'h4120_0000; tick();
        in_valid = 1'b0;
        check("rs_count2", 32'(count), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_count", 32'(count), 32'd0);
        check("rs_out_valid", 32'(out_valid), 32'd0);
        check("rs_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rs_after_valid", 32'(out_valid), 32'd0);
            check("rs_after_busy", 32'(busy), 32'd0);
        end
        in_valid = 1'b0;
        stim_q = '{32'h4040_0000, 32'h4080_0000};
        run_stream("post_reset", 2, 32'h40E0_0000, 1'b0, 0, 0);

        // Random integer-valued streams: every partial sum is exact in fp32.
        for (int t = 0; t < 10; t++) begin
            n = (t == 0) ? 255 : int'($urandom_range(30, 1));
            stim_q = {};
            sum = 0;
            for (int i = 0; i < n; i++) begin
                v = int'($urandom_range(2000)) - 1000;
                sum += v;
                stim_q.push_back(int_to_fp32(longint'(v)));
            end
            run_stream("random", n, int_to_fp32(sum), 1'b0, (t == 0) ? 0 : 25,
                       int'($urandom_range(3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
